// File: rtl/fetch_pkg.sv
// fetch_pkg: default widths, PC step, the NOP encoding and the queue entry
// type shared by the fetch front end and its bench.
package fetch_pkg;

    localparam int          ADDR_W    = 14;
    localparam int          INSTR_W   = 32;
    localparam int          PC_STEP   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One buffered fetch: the instruction word together with the PC it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: groups the instruction-memory port, the EX/MEM
// redirect and the IF/ID handshake. The master modport is the fetch unit;
// the slave modport is the surrounding pipeline and memory.
interface fetch_queue_unit_if #(
    parameter int ADDR_W  = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
);

    logic               imem_rd_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               id_ready;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;

    modport master (
        output imem_rd_en, imem_addr, if_valid, if_instr, if_pc,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_rd_en, imem_addr, if_valid, if_instr, if_pc,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with a single-cycle flush.
// DEPTH must be a power of two so the pointers wrap on their own.
// The head word is read combinationally from storage.
module fetch_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    // Storage, pointers and occupancy; flush empties the queue but keeps the stale words.
    // NOTE: state is written with <= so every register samples pre-edge values; = here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // NOTE: storage is reset because the empty-queue head is visible on if_instr/if_pc; a plain RAM would skip this.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end. It owns the PC and issues
// one read per cycle while the queue has room, counting the read in flight.
// Responses are tagged with their PC and queued for IF/ID. A redirect flushes
// the queue and bumps the epoch so the in-flight response is dropped.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_queue_unit #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = fetch_pkg::INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_queue_unit_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_flushes
`endif
);

    import fetch_pkg::*;

    localparam int                CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0]       OCC_LIMIT  = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [ADDR_W-1:0]         r_pc;
    logic [ADDR_W-1:0]         r_inflight_pc;
    logic                      r_inflight;
    logic                      r_inflight_epoch;
    logic                      r_epoch;

    logic [CW-1:0]             w_count;
    logic [ADDR_W+INSTR_W-1:0] w_head;
    logic                      w_if_valid;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_issue;
    logic [CW:0]               w_occupancy;

    // A pop coinciding with a redirect is discarded along with the rest of the queue.
    assign w_if_valid  = (w_count != '0);
    assign w_pop       = w_if_valid && bus.id_ready && !bus.redirect_valid;
    // Slots already claimed next cycle: queued + in flight - the one leaving now.
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    assign w_issue     = rst_n && !bus.redirect_valid && (w_occupancy < OCC_LIMIT);
    assign w_push      = r_inflight && (r_inflight_epoch == r_epoch) && !bus.redirect_valid;

    fetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({r_inflight_pc, bus.imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign bus.imem_rd_en = w_issue;
    assign bus.imem_addr  = r_pc;
    assign bus.if_valid   = w_if_valid;
    assign bus.if_pc      = w_head[ADDR_W+INSTR_W-1:INSTR_W];
    assign bus.if_instr   = w_head[INSTR_W-1:0];

    // PC, in-flight tracking and epoch; a redirect outranks issue and loads the aligned target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc             <= RESET_PC;
            r_inflight       <= 1'b0;
            r_inflight_pc    <= '0;
            r_inflight_epoch <= 1'b0;
            r_epoch          <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc       <= bus.redirect_pc & ALIGN_MASK;
            r_inflight <= 1'b0;
            r_epoch    <= ~r_epoch;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc             <= r_pc + ADDR_W'(PC_STEP);
                r_inflight_pc    <= r_pc;
                r_inflight_epoch <= r_epoch;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_flushes;

    // Free-running wrap-around counters of handed-off entries and redirect cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_fetched <= '0;
            r_stat_flushes <= '0;
        end else begin
            if (w_pop) begin
                r_stat_fetched <= r_stat_fetched + 32'd1;
            end
            if (bus.redirect_valid) begin
                r_stat_flushes <= r_stat_flushes + 32'd1;
            end
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_flushes = r_stat_flushes;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed bench for fetch_queue_unit. A table of
// per-cycle vectors covers reset, streaming and back-pressure. Hand-written
// sequences cover redirects, PC wrap (second instance, RESET_PC=0x3FF8) and
// a mid-stream reset. Stat checks are compiled when FETCH_STATS_EN is defined.
module tb_fetch_queue_unit;

    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_queue_unit_if #(.ADDR_W(14), .INSTR_W(32)) bus_lo ();
    fetch_queue_unit_if #(.ADDR_W(14), .INSTR_W(32)) bus_hi ();

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_lo, flushes_lo, fetched_hi, flushes_hi;
`endif

    fetch_queue_unit #(
        .ADDR_W (14), .INSTR_W (32), .DEPTH (4), .RESET_PC (14'h0000)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_lo)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (fetched_lo),
        .stat_flushes (flushes_lo)
`endif
    );

    fetch_queue_unit #(
        .ADDR_W (14), .INSTR_W (32), .DEPTH (4), .RESET_PC (14'h3FF8)
    ) u_dut_hi (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_hi)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (fetched_hi),
        .stat_flushes (flushes_hi)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Instruction memory contents: a recognisable word derived from the address.
    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return 32'hC0DE_0000 | {18'h0, a};
    endfunction

    // Synchronous instruction memory models: data the cycle after the request.
    always @(posedge clk) begin
        if (bus_lo.imem_rd_en) bus_lo.imem_rdata <= mem_word(bus_lo.imem_addr);
        if (bus_hi.imem_rd_en) bus_hi.imem_rdata <= mem_word(bus_hi.imem_addr);
    end

    // Queue occupancy must never exceed DEPTH.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && u_dut.w_count > 4) begin
            n_fail++;
            $display("FAIL occupancy: count=%0d exceeds 4", u_dut.w_count);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst_n                 = 1'b0;
        bus_lo.id_ready       = rdy;
        bus_lo.redirect_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic get_valid(input bit hi);
        return hi ? bus_hi.if_valid : bus_lo.if_valid;
    endfunction

    function automatic logic [13:0] get_pc(input bit hi);
        return hi ? bus_hi.if_pc : bus_lo.if_pc;
    endfunction

    function automatic logic [31:0] get_instr(input bit hi);
        return hi ? bus_hi.if_instr : bus_lo.if_instr;
    endfunction

    // Waits (bounded) for if_valid, checks the wait length, then n consecutive PCs from start.
    task automatic expect_stream(input bit hi, input logic [13:0] start, input int exp_wait,
                                 input int n, input string tag);
        int          waits = 0;
        logic [13:0] pc    = start;
        #1;
        while (!get_valid(hi) && waits < 20) begin
            @(posedge clk);
            #2;
            waits++;
        end
        check({tag, " first-valid latency"}, 32'(waits), 32'(exp_wait));
        for (int k = 0; k < n; k++) begin
            if (k != 0) begin
                @(posedge clk);
                #2;
            end
            check($sformatf("%s entry%0d if_valid", tag, k), 32'(get_valid(hi)), 32'd1);
            check($sformatf("%s entry%0d if_pc", tag, k), 32'(get_pc(hi)), 32'(pc));
            check($sformatf("%s entry%0d if_instr", tag, k), get_instr(hi), mem_word(pc));
            pc = pc + 14'd4;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        id_ready;
        logic        exp_rd;
        logic [13:0] exp_addr;
        logic        exp_valid;
        logic        chk_head;
        logic [13:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic rdy, input logic rd, input logic [13:0] addr,
                           input logic v, input logic ch, input logic [13:0] pc);
        vec_t e;
        e = '{r, rdy, rd, addr, v, ch, pc};
        vecs.push_back(e);
    endtask

    initial begin
        rst_n                 = 1'b0;
        bus_lo.id_ready       = 1'b0;
        bus_lo.redirect_valid = 1'b0;
        bus_lo.redirect_pc    = '0;
        bus_hi.id_ready       = 1'b1;
        bus_hi.redirect_valid = 1'b0;
        bus_hi.redirect_pc    = '0;

        // rst_n id_ready | rd_en addr | valid chk_head pc
        // Reset state, then streaming with id_ready=1 (first valid at N+2).
        add_vec(0, 1, 0, 14'h000, 0, 1, 14'h000);
        add_vec(1, 1, 1, 14'h000, 0, 0, 14'h000);
        add_vec(1, 1, 1, 14'h004, 0, 0, 14'h000);
        add_vec(1, 1, 1, 14'h008, 1, 1, 14'h000);
        add_vec(1, 1, 1, 14'h00C, 1, 1, 14'h004);
        add_vec(1, 1, 1, 14'h010, 1, 1, 14'h008);
        add_vec(1, 1, 1, 14'h014, 1, 1, 14'h00C);
        add_vec(1, 1, 1, 14'h018, 1, 1, 14'h010);
        // Reset asserted mid-stream: read request suppressed, queue still visible until the edge.
        add_vec(0, 0, 0, 14'h01C, 1, 1, 14'h014);
        add_vec(0, 0, 0, 14'h000, 0, 1, 14'h000);
        // id_ready=0 from reset: exactly four issues, then the PC holds at 0x10.
        add_vec(1, 0, 1, 14'h000, 0, 0, 14'h000);
        add_vec(1, 0, 1, 14'h004, 0, 0, 14'h000);
        add_vec(1, 0, 1, 14'h008, 1, 1, 14'h000);
        add_vec(1, 0, 1, 14'h00C, 1, 1, 14'h000);
        add_vec(1, 0, 0, 14'h010, 1, 1, 14'h000);
        add_vec(1, 0, 0, 14'h010, 1, 1, 14'h000);
        add_vec(1, 0, 0, 14'h010, 1, 1, 14'h000);
        // Release: drain in order with a fresh issue on every pop.
        add_vec(1, 1, 1, 14'h010, 1, 1, 14'h000);
        add_vec(1, 1, 1, 14'h014, 1, 1, 14'h004);
        add_vec(1, 1, 1, 14'h018, 1, 1, 14'h008);
        add_vec(1, 1, 1, 14'h01C, 1, 1, 14'h00C);
        add_vec(1, 1, 1, 14'h020, 1, 1, 14'h010);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n           = vecs[i].rst_n;
            bus_lo.id_ready = vecs[i].id_ready;
            #1;
            check($sformatf("vec%0d imem_rd_en", i), 32'(bus_lo.imem_rd_en), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d imem_addr", i), 32'(bus_lo.imem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d if_valid", i), 32'(bus_lo.if_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_head) begin
                check($sformatf("vec%0d if_pc", i), 32'(bus_lo.if_pc), 32'(vecs[i].exp_pc));
                check($sformatf("vec%0d if_instr", i), bus_lo.if_instr,
                      vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0);
            end
            next_cycle();
        end

        // Redirect to 0x103 with 3 queued + 1 in flight; a pop offered that cycle is dropped.
        do_reset(1'b0);
        repeat (4) next_cycle();
        #1;
        check("redir full imem_rd_en", 32'(bus_lo.imem_rd_en), 32'd0);
        check("redir full head pc", 32'(bus_lo.if_pc), 32'h000);
        bus_lo.redirect_valid = 1'b1;
        bus_lo.redirect_pc    = 14'h103;
        bus_lo.id_ready       = 1'b1;
        #1;
        check("redir cycle imem_rd_en", 32'(bus_lo.imem_rd_en), 32'd0);
        next_cycle();
        bus_lo.redirect_valid = 1'b0;
        #1;
        check("redir after if_valid", 32'(bus_lo.if_valid), 32'd0);
        check("redir after imem_rd_en", 32'(bus_lo.imem_rd_en), 32'd1);
        check("redir after imem_addr", 32'(bus_lo.imem_addr), 32'h100);
`ifdef FETCH_STATS_EN
        check("redir stat_flushes", fetched_lo === 32'hx ? 32'hx : flushes_lo, 32'd1);
        check("redir stat_fetched", fetched_lo, 32'd0);
`endif
        expect_stream(1'b0, 14'h100, 2, 4, "redir 0x103");

        // Back-to-back redirects: 0x40 then 0x80, the later one wins.
        bus_lo.redirect_valid = 1'b1;
        bus_lo.redirect_pc    = 14'h040;
        #1;
        check("b2b first imem_rd_en", 32'(bus_lo.imem_rd_en), 32'd0);
        next_cycle();
        bus_lo.redirect_pc = 14'h080;
        #1;
        check("b2b second imem_rd_en", 32'(bus_lo.imem_rd_en), 32'd0);
        next_cycle();
        bus_lo.redirect_valid = 1'b0;
        #1;
        check("b2b imem_rd_en", 32'(bus_lo.imem_rd_en), 32'd1);
        check("b2b imem_addr", 32'(bus_lo.imem_addr), 32'h080);
        check("b2b if_valid", 32'(bus_lo.if_valid), 32'd0);
`ifdef FETCH_STATS_EN
        check("b2b stat_flushes", flushes_lo, 32'd3);
`endif
        expect_stream(1'b0, 14'h080, 2, 3, "b2b");

        // PC wrap on the RESET_PC=0x3FF8 instance; main instance streams alongside.
        do_reset(1'b1);
        expect_stream(1'b1, 14'h3FF8, 2, 4, "wrap");
        bus_lo.id_ready = 1'b0;
        #1;
`ifdef FETCH_STATS_EN
        check("wrap stat_fetched", fetched_lo, 32'd4);
        check("wrap stat_flushes", flushes_lo, 32'd0);
`endif

        // One-cycle reset with two entries queued; fetch restarts at RESET_PC.
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("midreset imem_rd_en", 32'(bus_lo.imem_rd_en), 32'd0);
        check("midreset queued valid", 32'(bus_lo.if_valid), 32'd1);
        check("midreset queued pc", 32'(bus_lo.if_pc), 32'h010);
        next_cycle();
        rst_n           = 1'b1;
        bus_lo.id_ready = 1'b1;
        #1;
        check("postreset if_valid", 32'(bus_lo.if_valid), 32'd0);
        check("postreset if_pc", 32'(bus_lo.if_pc), 32'h000);
        check("postreset if_instr", bus_lo.if_instr, 32'h0);
        check("postreset imem_rd_en", 32'(bus_lo.imem_rd_en), 32'd1);
        check("postreset imem_addr", 32'(bus_lo.imem_addr), 32'h000);
`ifdef FETCH_STATS_EN
        check("postreset stat_fetched", fetched_lo, 32'd0);
        check("postreset stat_flushes", flushes_lo, 32'd0);
`endif
        expect_stream(1'b0, 14'h000, 2, 3, "postreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
